red_pitaya_na_averager_block: RTL

RED_PITAYA_NA_AVERAGER_BLOCK -- requirements
Module: red_pitaya_na_averager_block

---
 rtl/red_pitaya_na_averager_block.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_na_averager_block.sv
// Network-analyser averager: after a start event it waits "sleepcycles" clocks, sums
// "averages" samples per channel with saturation, then latches the sums as results.
module red_pitaya_na_averager_block #(
   parameter int CHANNELS = 2,
   parameter int INBITS   = 24,
   parameter int SUMBITS  = 62,
   parameter int CNTBITS  = 32
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [CHANNELS*INBITS-1:0]   dat_i,
   input  logic                         trig_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         valid_o,
   output logic                         ovf_o,
   input  logic [15:0]                  addr,
   input  logic                         wen,
   input  logic                         ren,
   input  logic [31:0]                  wdata,
   output logic                         ack,
   output logic [31:0]                  rdata
);

   typedef enum logic [1:0] {IDLE, SLEEP, AVG} state_t;

   localparam logic signed [SUMBITS-1:0] SUM_MAX = {1'b0, {(SUMBITS-1){1'b1}}};
   localparam logic signed [SUMBITS-1:0] SUM_MIN = {1'b1, {(SUMBITS-1){1'b0}}};

   state_t                     state;
   logic [CNTBITS-1:0]         averages;
   logic [CNTBITS-1:0]         sleepcycles;
   logic [CNTBITS-1:0]         sleep_rem;
   logic [CNTBITS-1:0]         avg_rem;
   logic signed [SUMBITS-1:0]  acc      [CHANNELS];
   logic signed [SUMBITS-1:0]  acc_next [CHANNELS];
   logic signed [SUMBITS:0]    wide     [CHANNELS];
   logic signed [SUMBITS-1:0]  result   [CHANNELS];
   logic [63:0]                res64    [CHANNELS];
   logic [CHANNELS-1:0]        sat;
   logic                       ctrl_wr;
   logic                       start;
   logic                       abort;
   logic [31:0]                rd_mux;

   assign ctrl_wr = wen && (addr == 16'h0108);
   assign abort   = ctrl_wr && wdata[1];
   assign start   = trig_i || (ctrl_wr && wdata[0]);
   assign busy_o  = (state != IDLE);

   // One guard bit above the accumulator exposes overflow of each add.
   always_comb begin
      sat = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         wide[k] = {acc[k][SUMBITS-1], acc[k]}
                 + {{(SUMBITS+1-INBITS){dat_i[k*INBITS+INBITS-1]}}, dat_i[k*INBITS +: INBITS]};
         sat[k] = (wide[k][SUMBITS] != wide[k][SUMBITS-1]);
         acc_next[k] = wide[k][SUMBITS-1:0];
         if (sat[k]) begin
            acc_next[k] = wide[k][SUMBITS] ? SUM_MIN : SUM_MAX;
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_res
      assign res64[g] = 64'(result[g]);
   end

   // Abort outranks start, and start outranks the completion of the current run.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state     <= IDLE;
         sleep_rem <= '0;
         avg_rem   <= '0;
         done_o    <= 1'b0;
         valid_o   <= 1'b0;
         ovf_o     <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            acc[k]    <= '0;
            result[k] <= '0;
         end
      end else begin
         done_o <= 1'b0;
         if (abort) begin
            state <= IDLE;
         end else if (start) begin
            for (int k = 0; k < CHANNELS; k++) begin
               acc[k] <= '0;
            end
            ovf_o     <= 1'b0;
            valid_o   <= 1'b0;
            sleep_rem <= sleepcycles;
            avg_rem   <= averages;
            if (sleepcycles != '0) begin
               state <= SLEEP;
            end else if (averages != '0) begin
               state <= AVG;
            end else begin
               state   <= IDLE;
               done_o  <= 1'b1;
               valid_o <= 1'b1;
               for (int k = 0; k < CHANNELS; k++) begin
                  result[k] <= '0;
               end
            end
         end else begin
            case (state)
               SLEEP: begin
                  sleep_rem <= sleep_rem - CNTBITS'(1);
                  if (sleep_rem == CNTBITS'(1)) begin
                     if (avg_rem != '0) begin
                        state <= AVG;
                     end else begin
                        state   <= IDLE;
                        done_o  <= 1'b1;
                        valid_o <= 1'b1;
                        for (int k = 0; k < CHANNELS; k++) begin
                           result[k] <= acc[k];
                        end
                     end
                  end
               end
               AVG: begin
                  for (int k = 0; k < CHANNELS; k++) begin
                     acc[k] <= acc_next[k];
                  end
                  if (sat != '0) begin
                     ovf_o <= 1'b1;
                  end
                  avg_rem <= avg_rem - CNTBITS'(1);
                  if (avg_rem == CNTBITS'(1)) begin
                     state   <= IDLE;
                     done_o  <= 1'b1;
                     valid_o <= 1'b1;
                     for (int k = 0; k < CHANNELS; k++) begin
                        result[k] <= acc_next[k];
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (addr)
         16'h0100: rd_mux = 32'(averages);
         16'h0104: rd_mux = 32'(sleepcycles);
         16'h010C: rd_mux = {29'd0, ovf_o, valid_o, busy_o};
         16'h0110: rd_mux = 32'(CHANNELS);
         16'h0114: rd_mux = 32'(SUMBITS);
         16'h0118: rd_mux = 32'(INBITS);
         default: begin
            for (int k = 0; k < CHANNELS; k++) begin
               if (addr == 16'(16'h0140 + 8*k)) rd_mux = res64[k][31:0];
               if (addr == 16'(16'h0144 + 8*k)) rd_mux = res64[k][63:32];
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         averages    <= '0;
         sleepcycles <= '0;
         ack         <= 1'b0;
         rdata       <= '0;
      end else begin
         ack <= wen | ren;
         if (wen) begin
            case (addr)
               16'h0100: averages    <= wdata[CNTBITS-1:0];
               16'h0104: sleepcycles <= wdata[CNTBITS-1:0];
               default: ;
            endcase
         end
         if (ren) begin
            rdata <= rd_mux;
         end
      end
   end

endmodule
